// File: rtl/alu_requester_if.sv
// alu_requester_if: handshake bundle between a host, the ALU command/response path
// and the completion consumer, as seen from the requester.
//   req_*  host operation in (valid/ready, op, a, b)
//   cmd_*  10-bit command word out to the ALU path
//   rsp_*  9-bit result back from the ALU path
//   cpl_*  completion record out (operands, result, mismatch, div-by-zero)
// master: the requester side. slave: host / ALU path / consumer side.
interface alu_requester_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;

  logic [9:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  logic [8:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  logic       cpl_valid;
  logic       cpl_ready;
  logic [1:0] cpl_op;
  logic [3:0] cpl_a;
  logic [3:0] cpl_b;
  logic [8:0] cpl_result;
  logic       cpl_mismatch;
  logic       cpl_dz;

  modport master (
    input  req_valid, req_op, req_a, req_b, cmd_ready, rsp_data, rsp_valid, cpl_ready,
    output req_ready, cmd_data, cmd_valid, rsp_ready, cpl_valid, cpl_op, cpl_a, cpl_b,
           cpl_result, cpl_mismatch, cpl_dz
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, cmd_ready, rsp_data, rsp_valid, cpl_ready,
    input  req_ready, cmd_data, cmd_valid, rsp_ready, cpl_valid, cpl_op, cpl_a, cpl_b,
           cpl_result, cpl_mismatch, cpl_dz
  );
endinterface

// File: rtl/alu_requester.sv
// alu_requester: initiator end of the ALU command/response path. Packs host operations
// into {op, b, a} command words, keeps up to DEPTH in-flight operand sets in issue order,
// checks each returned result against a locally computed value and emits a completion.
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   bus           alu_requester_if.master (req/cmd/rsp/cpl handshakes)
//   issued_cnt    commands issued, saturating
//   mismatch_cnt  result mismatches, saturating
//   orphan_err    sticky: response with nothing outstanding
//   timeout_err   sticky: response watchdog expired
module alu_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  alu_requester_if.master bus,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     mismatch_cnt,
  output logic            orphan_err,
  output logic            timeout_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [PtrW:0]  DepthVal   = (PtrW + 1)'(DEPTH);
  localparam logic [WdW-1:0] TimeoutVal = WdW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [9:0]      cmd_data_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [WdW-1:0]  wd_q;

  // Outstanding operand storage; contents are only meaningful below count_q.
  logic [1:0] q_op [DEPTH];
  logic [3:0] q_a  [DEPTH];
  logic [3:0] q_b  [DEPTH];

  logic       cpl_valid_q, cpl_mismatch_q, cpl_dz_q;
  logic [1:0] cpl_op_q;
  logic [3:0] cpl_a_q, cpl_b_q;
  logic [8:0] cpl_result_q;

  logic       req_fire, rsp_fire, pop, orphan;
  logic [1:0] head_op;
  logic [3:0] head_a, head_b;
  logic [8:0] exp_res;
  logic       exp_dz, mismatch;

  assign bus.req_ready = ((state_q == StIdle) || bus.cmd_ready) && (count_q < DepthVal) && !reset;
  assign bus.rsp_ready = !cpl_valid_q || bus.cpl_ready;
  assign bus.cmd_valid = (state_q == StSend);
  assign bus.cmd_data  = cmd_data_q;

  assign bus.cpl_valid    = cpl_valid_q;
  assign bus.cpl_op       = cpl_op_q;
  assign bus.cpl_a        = cpl_a_q;
  assign bus.cpl_b        = cpl_b_q;
  assign bus.cpl_result   = cpl_result_q;
  assign bus.cpl_mismatch = cpl_mismatch_q;
  assign bus.cpl_dz       = cpl_dz_q;

  assign req_fire = bus.req_valid && bus.req_ready;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;
  assign pop      = rsp_fire && (count_q != '0);
  assign orphan   = rsp_fire && (count_q == '0);

  assign head_op = q_op[rd_ptr_q];
  assign head_a  = q_a[rd_ptr_q];
  assign head_b  = q_b[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_fire) state_d = StSend;
      // A same-cycle new request keeps us in StSend for back-to-back issue.
      StSend:  if (bus.cmd_ready && !req_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Expected result: add/sub wrap to 4 bits, mul is 8 bits, div truncates.
  always_comb begin
    exp_res = '0;
    exp_dz  = 1'b0;
    unique case (head_op)
      2'd0: exp_res = {5'd0, head_a + head_b};
      2'd1: exp_res = {5'd0, head_a - head_b};
      2'd2: exp_res = {1'b0, {4'd0, head_a} * {4'd0, head_b}};
      2'd3: begin
        if (head_b == 4'd0) exp_dz = 1'b1;
        else                exp_res = {5'd0, head_a / head_b};
      end
      default: exp_res = '0;
    endcase
  end

  assign mismatch = (bus.rsp_data != exp_res) && !exp_dz;

  always_ff @(posedge clk) begin
    if (req_fire) begin
      q_op[wr_ptr_q] <= bus.req_op;
      q_a[wr_ptr_q]  <= bus.req_a;
      q_b[wr_ptr_q]  <= bus.req_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cmd_data_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wd_q           <= '0;
      issued_cnt     <= '0;
      mismatch_cnt   <= '0;
      orphan_err     <= 1'b0;
      timeout_err    <= 1'b0;
      cpl_valid_q    <= 1'b0;
      cpl_op_q       <= '0;
      cpl_a_q        <= '0;
      cpl_b_q        <= '0;
      cpl_result_q   <= '0;
      cpl_mismatch_q <= 1'b0;
      cpl_dz_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (req_fire) begin
        cmd_data_q <= {bus.req_op, bus.req_b, bus.req_a};
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
      end

      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (req_fire && !pop)      count_q <= count_q + 1'b1;
      else if (!req_fire && pop) count_q <= count_q - 1'b1;

      if (pop) begin
        cpl_valid_q    <= 1'b1;
        cpl_op_q       <= head_op;
        cpl_a_q        <= head_a;
        cpl_b_q        <= head_b;
        cpl_result_q   <= bus.rsp_data;
        cpl_mismatch_q <= mismatch;
        cpl_dz_q       <= exp_dz;
        if (mismatch && (mismatch_cnt != 16'hFFFF)) mismatch_cnt <= mismatch_cnt + 16'd1;
      end else if (bus.cpl_ready) begin
        cpl_valid_q <= 1'b0;
      end

      if (orphan) orphan_err <= 1'b1;

      // Watchdog holds at TIMEOUT; the flag follows one cycle later.
      if (rsp_fire || (count_q == '0)) wd_q <= '0;
      else if (wd_q != TimeoutVal)     wd_q <= wd_q + 1'b1;
      if (wd_q == TimeoutVal) timeout_err <= 1'b1;
    end
  end

endmodule
